// File: rtl/fifo_burst_reader.sv
// Drains a FIFO into a byte transmitter in bursts of up to BURST_MAX bytes.
// Optional macro BURST_HEADER_EN prefixes each burst with HEADER_BYTE.
module fifo_burst_reader #(
  parameter int WIDTH          = 8,
  parameter int BURST_MAX      = 58,
  parameter int TIMEOUT_CYCLES = 1000
`ifdef BURST_HEADER_EN
  ,
  parameter logic [WIDTH-1:0] HEADER_BYTE = 8'hA5
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic             fifo_reach_limit,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read_ins,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             burst_done
);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef BURST_HEADER_EN
    S_HEADER,
`endif
    S_READ,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [15:0] IDLE_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  BURST_LAST = 8'(BURST_MAX);

`ifdef BURST_HEADER_EN
  localparam state_t START_STATE = S_HEADER;
`else
  localparam state_t START_STATE = S_READ;
`endif

  state_t           state_reg, state_next;
  logic [15:0]      idle_cnt_reg, idle_cnt_next;
  logic [7:0]       byte_cnt_reg, byte_cnt_next;
  logic [WIDTH-1:0] tx_data_reg, tx_data_next;
  logic [7:0]       byte_cnt_inc;
  logic             start_burst;

  assign byte_cnt_inc = byte_cnt_reg + 8'd1;
  // Fill level and timeout may coincide; either one triggers the same single start.
  assign start_burst  = enable && !fifo_empty &&
                        (fifo_reach_limit || (idle_cnt_reg == IDLE_LAST));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      idle_cnt_reg <= '0;
      byte_cnt_reg <= '0;
      tx_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      idle_cnt_reg <= idle_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      tx_data_reg  <= tx_data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idle_cnt_next = idle_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    tx_data_next  = tx_data_reg;
    fifo_read_ins = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = tx_data_reg;
    burst_done    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (fifo_empty) begin
          idle_cnt_next = '0;
        end else if (idle_cnt_reg != IDLE_LAST) begin
          idle_cnt_next = idle_cnt_reg + 16'd1;
        end
        if (start_burst) begin
          idle_cnt_next = '0;
          state_next    = START_STATE;
        end
      end
`ifdef BURST_HEADER_EN
      S_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = HEADER_BYTE;
        if (tx_ready) begin
          state_next = S_READ;
        end
      end
`endif
      S_READ: begin
        fifo_read_ins = 1'b1;
        state_next    = S_CAPTURE;
      end
      S_CAPTURE: begin
        tx_data_next = fifo_data;
        state_next   = S_SEND;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          byte_cnt_next = byte_cnt_inc;
          // A full burst or a drained FIFO both close the burst.
          if ((byte_cnt_inc == BURST_LAST) || fifo_empty) begin
            state_next = S_DONE;
          end else begin
            state_next = S_READ;
          end
        end
      end
      S_DONE: begin
        burst_done    = 1'b1;
        byte_cnt_next = '0;
        state_next    = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy = (state_reg != S_IDLE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: FIFO model, scoreboard, vector table,
// corner sequences and a randomized phase. Works with or without BURST_HEADER_EN.
`timescale 1ns/1ps
module tb_fifo_burst_reader;
  localparam int WIDTH          = 8;
  localparam int BURST_MAX      = 58;
  localparam int TIMEOUT_CYCLES = 10;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             fifo_empty;
  logic             fifo_reach_limit;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_read_ins;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             burst_done;

  fifo_burst_reader #(
    .WIDTH(WIDTH),
    .BURST_MAX(BURST_MAX),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .fifo_reach_limit(fifo_reach_limit),
    .fifo_data(fifo_data),
    .fifo_read_ins(fifo_read_ins),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .burst_done(burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: circular store, data registered one cycle after the read strobe.
  logic [7:0] fifo_mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int limit_level = 1000;
  logic [7:0] rd_q [$];

  assign fifo_empty       = (wr_ptr == rd_ptr);
  assign fifo_reach_limit = ((wr_ptr - rd_ptr) >= limit_level);

  always @(posedge clk) begin
    if (fifo_read_ins && !fifo_empty) begin
      fifo_data <= fifo_mem[rd_ptr % 4096];
      rd_ptr    <= rd_ptr + 1;
      if (rst_n) rd_q.push_back(fifo_mem[rd_ptr % 4096]);
    end
    if (!rst_n) rd_q.delete();
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: samples just after the falling edge, i.e. what the next rising edge sees.
  int sent_total = 0;
  int strobes    = 0;
  int done_count = 0;
  int cur_len    = 0;
  int last_payload = -1;
  int burst_lens [$];
  bit hdr_pending = 1'b0;
  bit prev_busy   = 1'b0;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      cur_len     = 0;
      hdr_pending = 1'b0;
      prev_busy   = 1'b0;
    end else begin
      if (fifo_read_ins) begin
        strobes++;
        chk("read_while_empty", int'(fifo_empty), 0);
      end
`ifdef BURST_HEADER_EN
      if (busy && !prev_busy) hdr_pending = 1'b1;
`endif
      if (tx_valid && tx_ready) begin
        if (hdr_pending) begin
          chk("header_byte", int'(tx_data), 'hA5);
          hdr_pending = 1'b0;
        end else begin
          if (rd_q.size() == 0) begin
            chk("payload_without_read", 1, 0);
          end else begin
            chk("payload_data", int'(tx_data), int'(rd_q.pop_front()));
          end
          last_payload = int'(tx_data);
          sent_total++;
          cur_len++;
        end
      end
      if (burst_done) begin
        checks++;
        if (cur_len < 1 || cur_len > BURST_MAX) begin
          errors++;
          $display("FAIL burst_len_range: got %0d, expected 1..%0d", cur_len, BURST_MAX);
        end
        done_count++;
        $display("burst %0d done: %0d payload bytes", done_count, cur_len);
        burst_lens.push_back(cur_len);
        cur_len = 0;
      end
      prev_busy = busy;
    end
  end

  int next_val = 0;

  task automatic push_bytes(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr % 4096] = rnd ? 8'($urandom) : 8'(next_val);
      next_val = (next_val + 1) % 256;
      wr_ptr++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input bit rand_ready, input string name);
    int n;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
      if (fifo_empty && !busy) break;
      n++;
    end
    if (n >= 3000) chk({name, "_drain_timeout"}, n, 0);
    tx_ready = 1'b1;
  endtask

  function automatic int first_len();
    return (burst_lens.size() == 0) ? -1 : burst_lens[0];
  endfunction

  function automatic int last_len();
    return (burst_lens.size() == 0) ? -1 : burst_lens[burst_lens.size() - 1];
  endfunction

  typedef struct {
    int n_bytes;
    int limit;
    bit rand_ready;
    int exp_bursts;
    int exp_first;
    int exp_last;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int s0, t0, d0, cyc, d_hold, expv, pushed;
    rst_n    = 1'b0;
    enable   = 1'b0;
    tx_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_fifo_read_ins", int'(fifo_read_ins), 0);
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_burst_done", int'(burst_done), 0);
    rst_n = 1'b1;

    // Preloaded bursts: expected lengths follow from BURST_MAX chunking
    vecs[0] = '{58,  58,   1'b0, 1, 58, 58};
    vecs[1] = '{100, 58,   1'b0, 2, 58, 42};
    vecs[2] = '{3,   1000, 1'b0, 1, 3,  3};
    vecs[3] = '{5,   1,    1'b1, 1, 5,  5};
    vecs[4] = '{116, 58,   1'b1, 2, 58, 58};
    for (int v = 0; v < 5; v++) begin
      do_reset();
      enable      = 1'b0;
      limit_level = vecs[v].limit;
      burst_lens.delete();
      s0 = strobes; t0 = sent_total; d0 = done_count;
      expv = (next_val + vecs[v].n_bytes - 1) % 256;
      push_bytes(vecs[v].n_bytes, 1'b0);
      @(negedge clk);
      enable = 1'b1;
      drain(vecs[v].rand_ready, "vec");
      $display("vector %0d: %0d bytes, %0d bursts", v, vecs[v].n_bytes, done_count - d0);
      chk("vec_bursts", done_count - d0, vecs[v].exp_bursts);
      chk("vec_first_len", first_len(), vecs[v].exp_first);
      chk("vec_last_len", last_len(), vecs[v].exp_last);
      chk("vec_strobes", strobes - s0, vecs[v].n_bytes);
      chk("vec_sent", sent_total - t0, vecs[v].n_bytes);
      chk("vec_last_byte", last_payload, expv);
      chk("vec_busy_end", int'(busy), 0);
    end

    // Partial burst after timeout: busy rises TIMEOUT_CYCLES edges after data arrives
    do_reset();
    limit_level = 1000;
    enable = 1'b1;
    tx_ready = 1'b1;
    burst_lens.delete();
    repeat (3) @(negedge clk);
    push_bytes(3, 1'b0);
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (busy) break;
    end
    chk("timeout_latency", cyc, TIMEOUT_CYCLES);
    drain(1'b0, "timeout");
    chk("timeout_len", last_len(), 3);
    chk("timeout_busy", int'(busy), 0);

    // Back-pressure: tx_valid and tx_data hold for 5 stalled cycles, no extra strobe
    do_reset();
    limit_level = 1;
    enable = 1'b0;
    t0 = sent_total;
    expv = (next_val + 1) % 256;
    push_bytes(3, 1'b0);
    @(negedge clk);
    enable = 1'b1;
    cyc = 0;
    while (sent_total == t0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b0;
    cyc = 0;
    while (!tx_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_reached_send", int'(tx_valid), 1);
    d_hold = int'(tx_data);
    s0 = strobes;
    chk("stall_data", d_hold, expv);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", int'(tx_valid), 1);
      chk("stall_hold", int'(tx_data), d_hold);
      chk("stall_strobes", strobes, s0);
      @(negedge clk);
    end
    tx_ready = 1'b1;
    drain(1'b0, "stall");
    chk("stall_sent", sent_total - t0, 3);

    // Reset during the 4th SEND abandons the burst without burst_done
    do_reset();
    limit_level = 1;
    enable = 1'b0;
    burst_lens.delete();
    s0 = strobes; t0 = sent_total;
    push_bytes(10, 1'b0);
    @(negedge clk);
    enable = 1'b1;
    cyc = 0;
    while (sent_total < t0 + 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b0;
    cyc = 0;
    while (!tx_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    d0 = done_count;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_read_ins", int'(fifo_read_ins), 0);
    chk("midrst_tx_valid", int'(tx_valid), 0);
    chk("midrst_tx_data", int'(tx_data), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_burst_done", int'(burst_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    chk("midrst_no_done", done_count, d0);
    t0 = sent_total;
    drain(1'b0, "midrst");
    chk("midrst_next_len", last_len(), 6);
    chk("midrst_sent_after", sent_total - t0, 6);
    chk("midrst_strobes", strobes - s0, 10);

    // Randomized traffic: every pushed byte must come out in order, bursts bounded
    do_reset();
    s0 = strobes; t0 = sent_total; d0 = done_count;
    pushed = 0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if (c % 500 == 0) limit_level = $urandom_range(1, 80);
      tx_ready = ($urandom_range(0, 3) != 0);
      enable   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) begin
        cyc = $urandom_range(1, 4);
        push_bytes(cyc, 1'b1);
        pushed += cyc;
      end
    end
    enable = 1'b1;
    drain(1'b0, "random");
    $display("random phase: %0d bytes pushed, %0d bursts", pushed, done_count - d0);
    chk("random_sent", sent_total - t0, pushed);
    chk("random_strobes", strobes - s0, pushed);
    chk("random_min_bursts", int'((done_count - d0) >= (pushed + BURST_MAX - 1) / BURST_MAX), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
